pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 161 ++++++++++++++++
 tb/tb_pc_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program counter generator with optional return-address stack.
//
// Selects the next PC by fixed priority (exception, return, register jump,
// absolute jump, taken branch, sequential) and loads it into the PC register
// on every accepted clock edge. An exception is accepted even while stalled.
//
// Optional feature macro: PC_GEN_RAS_EN
//   defined   : a RAS_DEPTH-entry circular return-address stack supplies
//               return targets; call pushes pc+4, ret pops.
//   undefined : no stack storage; ret behaves exactly like jr, call is
//               ignored, ras_empty is tied 1 and ras_ovf tied 0.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             hold the current PC (overridden by exc)
//   br, zero          conditional branch and its condition
//   jump, jr          absolute / register-indirect jump
//   call, ret         link (push return address) / return (pop)
//   exc               exception redirect to EXC_VEC
//   pc_br, pc_jump,   branch, jump and register targets
//   pc_jr
//   pc, pc_plus_4     current PC and PC+4 (modulo 2^AW)
//   npc               combinational next PC
//   misalign          npc is not word aligned (informational only)
//   ras_empty         stack holds no entries
//   ras_ovf           sticky: a push ever overwrote the oldest entry
// ---------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned   AW        = 32,
   parameter logic [AW-1:0] RESET_PC  = 32'h0000_3000,
   parameter logic [AW-1:0] EXC_VEC   = 32'h0000_4180,
   parameter int unsigned   RAS_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          br,
   input  logic          zero,
   input  logic          jump,
   input  logic          jr,
   input  logic          call,
   input  logic          ret,
   input  logic          exc,
   input  logic [AW-1:0] pc_br,
   input  logic [AW-1:0] pc_jump,
   input  logic [AW-1:0] pc_jr,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pc_plus_4,
   output logic [AW-1:0] npc,
   output logic          misalign,
   output logic          ras_empty,
   output logic          ras_ovf
);

   localparam logic [AW-1:0] PC_INC = AW'(4);

   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] ret_target;
   logic          accept;

   assign accept    = exc | ~stall;
   assign pc        = pc_q;
   // Natural wrap from the top of the address space back to 0.
   assign pc_plus_4 = pc_q + PC_INC;
   assign misalign  = |npc[1:0];

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      npc = pc_plus_4;
      if (exc)             npc = EXC_VEC;
      else if (ret)        npc = ret_target;
      else if (jr)         npc = pc_jr;
      else if (jump)       npc = pc_jump;
      else if (br && zero) npc = pc_br;
   end

   assign pc_d = accept ? npc : pc_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

`ifdef PC_GEN_RAS_EN
   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

   // sp_q indexes the next free slot; the top entry sits at sp_q-1. Because
   // the depth is a power of two the pointer wraps by itself, so a push while
   // full lands on the oldest entry.
   logic [AW-1:0] ras_mem_q [RAS_DEPTH];
   logic [PW-1:0] sp_q, sp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] top_idx;
   logic          ras_op_en;
   logic          ras_wr_en;
   logic [PW-1:0] ras_wr_idx;

   assign top_idx    = sp_q - PW'(1);
   assign ras_empty  = (cnt_q == '0);
   assign ras_ovf    = ovf_q;
   assign ret_target = ras_empty ? pc_jr : ras_mem_q[top_idx];
   // Stack only moves on accepted, non-exception cycles.
   assign ras_op_en  = ~stall & ~exc;

   always_comb begin
      sp_d       = sp_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      ras_wr_en  = 1'b0;
      ras_wr_idx = sp_q;
      if (ras_op_en) begin
         if (call && ret) begin
            // Replace-top: the return consumes the top, the call refills it.
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_idx;
         end else if (call) begin
            ras_wr_en = 1'b1;
            sp_d      = sp_q + PW'(1);
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + (PW+1)'(1);
         end else if (ret && !ras_empty) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // NOTE: the stack entries are deliberately left without reset; the count
   // marks which entries are valid, so their contents never matter after
   // reset and the array can map onto plain storage.
   always_ff @(posedge clk) begin
      if (ras_wr_en) ras_mem_q[ras_wr_idx] <= pc_plus_4;
   end
`else
   logic unused_call;

   assign unused_call = call;
   assign ret_target  = pc_jr;
   assign ras_empty   = 1'b1;
   assign ras_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed self-checking bench for pc_gen.
// Exercises sequential flow, redirect priority, stall/exception, misalign,
// asynchronous reset mid-redirect, and the AW=16 wrap. Return-stack
// scenarios run when PC_GEN_RAS_EN is defined; otherwise the bench checks
// that ret acts as jr and call is ignored.
// ---------------------------------------------------------------------------
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, br, zero, jump, jr, call, ret, exc;
   logic [31:0] pc_br, pc_jump, pc_jr;
   logic [31:0] pc, pc_plus_4, npc;
   logic        misalign, ras_empty, ras_ovf;

   logic        rst16_n;
   logic        jr16;
   logic [15:0] pc_jr16;
   logic [15:0] pc16, pc_plus_4_16, npc16;
   logic        misalign16, ras_empty16, ras_ovf16;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   pc_gen u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .br        (br),
      .zero      (zero),
      .jump      (jump),
      .jr        (jr),
      .call      (call),
      .ret       (ret),
      .exc       (exc),
      .pc_br     (pc_br),
      .pc_jump   (pc_jump),
      .pc_jr     (pc_jr),
      .pc        (pc),
      .pc_plus_4 (pc_plus_4),
      .npc       (npc),
      .misalign  (misalign),
      .ras_empty (ras_empty),
      .ras_ovf   (ras_ovf)
   );

   pc_gen #(
      .AW       (16),
      .RESET_PC (16'hFFFC),
      .EXC_VEC  (16'h4180)
   ) u_dut16 (
      .clk       (clk),
      .rst_n     (rst16_n),
      .stall     (1'b0),
      .br        (1'b0),
      .zero      (1'b0),
      .jump      (1'b0),
      .jr        (jr16),
      .call      (1'b0),
      .ret       (1'b0),
      .exc       (1'b0),
      .pc_br     (16'h0000),
      .pc_jump   (16'h0000),
      .pc_jr     (pc_jr16),
      .pc        (pc16),
      .pc_plus_4 (pc_plus_4_16),
      .npc       (npc16),
      .misalign  (misalign16),
      .ras_empty (ras_empty16),
      .ras_ovf   (ras_ovf16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; br = 0; zero = 0; jump = 0; jr = 0;
      call = 0; ret = 0; exc = 0;
      pc_br = '0; pc_jump = '0; pc_jr = '0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [3] = '{32'h3004, 32'h3008, 32'h300C};
      idle();
      rst_n = 0; rst16_n = 0; jr16 = 0; pc_jr16 = '0;
      tick(); tick();
      total++; if (pc !== 32'h3000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); else passed++;
      total++; if (pc_plus_4 !== 32'h3004) $display("FAIL reset_pc4 got=%h exp=%h", pc_plus_4, 32'h3004); else passed++;
      total++; if (ras_empty !== 1'b1 || ras_ovf !== 1'b0)
         $display("FAIL reset_ras got=%b%b exp=10", ras_empty, ras_ovf); else passed++;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (pc !== exp_seq[i]) $display("FAIL seq%0d got=%h exp=%h", i, pc, exp_seq[i]); else passed++;
      end
   endtask

   task automatic test_branch();
      br = 1; zero = 1; jump = 1; pc_jump = 32'h3400; pc_br = 32'h3100;
      #1;
      total++; if (npc !== 32'h3400) $display("FAIL jump_over_br_npc got=%h exp=%h", npc, 32'h3400); else passed++;
      tick();
      total++; if (pc !== 32'h3400) $display("FAIL jump_pc got=%h exp=%h", pc, 32'h3400); else passed++;
      jump = 0; #1;
      total++; if (npc !== 32'h3100) $display("FAIL br_npc got=%h exp=%h", npc, 32'h3100); else passed++;
      tick();
      total++; if (pc !== 32'h3100) $display("FAIL br_pc got=%h exp=%h", pc, 32'h3100); else passed++;
      zero = 0; #1;
      total++; if (npc !== 32'h3104) $display("FAIL br_nt_npc got=%h exp=%h", npc, 32'h3104); else passed++;
      tick();
      total++; if (pc !== 32'h3104) $display("FAIL br_nt_pc got=%h exp=%h", pc, 32'h3104); else passed++;
      idle();
   endtask

   task automatic test_stall_exc();
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (pc !== 32'h3104) $display("FAIL stall%0d got=%h exp=%h", i, pc, 32'h3104); else passed++;
      end
      exc = 1; call = 1; jump = 1; pc_jump = 32'h3400; #1;
      total++; if (npc !== 32'h4180) $display("FAIL exc_npc got=%h exp=%h", npc, 32'h4180); else passed++;
      tick();
      total++; if (pc !== 32'h4180) $display("FAIL exc_pc got=%h exp=%h", pc, 32'h4180); else passed++;
      total++; if (ras_empty !== 1'b1) $display("FAIL exc_ras got=%b exp=1", ras_empty); else passed++;
      idle();
   endtask

   task automatic test_priority_misalign();
      exc = 1; ret = 1; jr = 1; jump = 1; br = 1; zero = 1;
      pc_jr = 32'h5002; pc_jump = 32'h3400; pc_br = 32'h3100; #1;
      total++; if (npc !== 32'h4180) $display("FAIL prio_exc got=%h exp=%h", npc, 32'h4180); else passed++;
      exc = 0; ret = 0; #1;
      total++; if (npc !== 32'h5002) $display("FAIL prio_jr got=%h exp=%h", npc, 32'h5002); else passed++;
      total++; if (misalign !== 1'b1) $display("FAIL misalign got=%b exp=1", misalign); else passed++;
      tick();
      total++; if (pc !== 32'h5002) $display("FAIL jr_pc got=%h exp=%h", pc, 32'h5002); else passed++;
      idle(); #1;
      total++; if (misalign !== 1'b1 || npc !== 32'h5006)
         $display("FAIL seq_misalign got=%b/%h exp=1/5006", misalign, npc); else passed++;
      jump = 1; pc_jump = 32'h3000; #1;
      total++; if (misalign !== 1'b0) $display("FAIL aligned got=%b exp=0", misalign); else passed++;
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      stall = 1; jump = 1; pc_jump = 32'h3400;
      tick();
      jump = 0; exc = 1; #2;
      rst_n = 0; #1;
      total++; if (pc !== 32'h3000) $display("FAIL async_rst got=%h exp=%h", pc, 32'h3000); else passed++;
      tick();
      total++; if (pc !== 32'h3000) $display("FAIL rst_hold got=%h exp=%h", pc, 32'h3000); else passed++;
      idle(); rst_n = 1;
      tick();
      total++; if (pc !== 32'h3004) $display("FAIL rst_release got=%h exp=%h", pc, 32'h3004); else passed++;
   endtask

`ifdef PC_GEN_RAS_EN
   task automatic test_ras_basic();
      jump = 1; pc_jump = 32'h3010; tick();
      call = 1; pc_jump = 32'h3020; tick();
      pc_jump = 32'h3100; tick();
      idle(); ret = 1; pc_jr = 32'hDEAD_0000; #1;
      total++; if (npc !== 32'h3024) $display("FAIL ret1 got=%h exp=%h", npc, 32'h3024); else passed++;
      tick();
      total++; if (npc !== 32'h3014) $display("FAIL ret2 got=%h exp=%h", npc, 32'h3014); else passed++;
      tick();
      total++; if (ras_empty !== 1'b1) $display("FAIL ret_empty got=%b exp=1", ras_empty); else passed++;
      total++; if (npc !== 32'hDEAD_0000) $display("FAIL ret3 got=%h exp=%h", npc, 32'hDEAD_0000); else passed++;
      idle();
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp_pop [4] = '{32'h3028, 32'h3024, 32'h3020, 32'h301C};
      // pc is 0x3014 here; five pushes of 3018..3028.
      call = 1;
      for (int i = 0; i < 5; i++) tick();
      idle();
      total++; if (ras_ovf !== 1'b1) $display("FAIL ovf got=%b exp=1", ras_ovf); else passed++;
      ret = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (npc !== exp_pop[i]) $display("FAIL pop%0d got=%h exp=%h", i, npc, exp_pop[i]); else passed++;
         tick();
      end
      total++; if (ras_empty !== 1'b1) $display("FAIL pop_empty got=%b exp=1", ras_empty); else passed++;
      // pc is 0x301C: push 0x3020, then call&ret at 0x3020.
      ret = 0; call = 1; tick();
      ret = 1; #1;
      total++; if (npc !== 32'h3020) $display("FAIL repl_npc got=%h exp=%h", npc, 32'h3020); else passed++;
      tick();
      total++; if (ras_empty !== 1'b0) $display("FAIL repl_cnt got=%b exp=0", ras_empty); else passed++;
      call = 0; #1;
      total++; if (npc !== 32'h3024) $display("FAIL repl_top got=%h exp=%h", npc, 32'h3024); else passed++;
      tick();
      total++; if (ras_empty !== 1'b1 || ras_ovf !== 1'b1)
         $display("FAIL repl_end got=%b%b exp=11", ras_empty, ras_ovf); else passed++;
      idle();
   endtask
`else
   task automatic test_ret_as_jr();
      ret = 1; call = 1; pc_jr = 32'hDEAD_0000; #1;
      total++; if (npc !== 32'hDEAD_0000) $display("FAIL ret_jr got=%h exp=%h", npc, 32'hDEAD_0000); else passed++;
      tick();
      total++; if (pc !== 32'hDEAD_0000) $display("FAIL ret_pc got=%h exp=%h", pc, 32'hDEAD_0000); else passed++;
      total++; if (ras_empty !== 1'b1 || ras_ovf !== 1'b0)
         $display("FAIL no_ras got=%b%b exp=10", ras_empty, ras_ovf); else passed++;
      idle();
   endtask
`endif

   task automatic test_wrap16();
      rst16_n = 1; #1;
      total++; if (pc16 !== 16'hFFFC || pc_plus_4_16 !== 16'h0000)
         $display("FAIL w16_reset got=%h/%h exp=fffc/0000", pc16, pc_plus_4_16); else passed++;
      tick();
      total++; if (pc16 !== 16'h0000) $display("FAIL w16_wrap got=%h exp=%h", pc16, 16'h0000); else passed++;
      jr16 = 1; pc_jr16 = 16'h3002; #1;
      total++; if (misalign16 !== 1'b1) $display("FAIL w16_misalign got=%b exp=1", misalign16); else passed++;
      tick();
      total++; if (pc16 !== 16'h3002) $display("FAIL w16_jr got=%h exp=%h", pc16, 16'h3002); else passed++;
      jr16 = 0;
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall_exc();
      test_priority_misalign();
      test_reset_mid();
`ifdef PC_GEN_RAS_EN
      test_ras_basic();
      test_ras_overflow();
`else
      test_ret_as_jr();
`endif
      test_wrap16();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
